// File: rtl/common_mem_arbiter_pkg.sv
// Shared definitions for the common memory arbiter: FSM encoding and default widths.
package common_mem_arbiter_pkg;

  localparam int unsigned DefAddrW = 2;
  localparam int unsigned DefOdW   = 3;
  localparam int unsigned DefDataW = 32;

  // Requester index width; covers up to 8 requesters.
  localparam int unsigned IdxW = 3;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StAck   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/common_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at N_REQ.
module common_mem_arbiter_rr_pick
  import common_mem_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 8
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IdxW-1:0]  ptr_i,
  output logic [IdxW-1:0]  idx_o,
  output logic             found_o
);

  logic [IdxW:0] cand;

  // Scan ptr, ptr+1, ... modulo N_REQ; the first hit wins.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    cand    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = {1'b0, ptr_i} + (IdxW + 1)'(i);
      if (cand >= (IdxW + 1)'(N_REQ)) begin
        cand = cand - (IdxW + 1)'(N_REQ);
      end
      if (!found_o && req_i[cand[IdxW-1:0]]) begin
        found_o = 1'b1;
        idx_o   = cand[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/common_mem_arbiter.sv
// Round-robin arbiter sharing one common-memory port between N_REQ requesters.
// Each transaction runs IDLE -> ISSUE -> ACK. Optional macro MEM_ARB_LOCK_EN lets a
// locked winner go straight from ACK back to ISSUE for atomic read-modify-write.
module common_mem_arbiter
  import common_mem_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ  = 8,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned OD_W   = DefOdW,
  parameter int unsigned DATA_W = DefDataW
) (
  input  logic                    clk_in,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        req_we,
  input  logic [N_REQ-1:0]        req_lock,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*OD_W-1:0]   req_rd_od,
  input  logic [N_REQ*DATA_W-1:0] req_wd_data,
  output logic [N_REQ-1:0]        gnt,
  output logic                    ack,
  output logic [2:0]              ack_id,
  output logic [DATA_W-1:0]       rd_data,
  output logic [15:0]             txn_cnt,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [OD_W-1:0]         mem_rd_od,
  output logic [DATA_W-1:0]       mem_wd_data,
  input  logic [DATA_W-1:0]       mem_rd_data
);

  localparam logic [IdxW-1:0] LastIdx = IdxW'(N_REQ - 1);

  arb_state_e        state_q, state_d;
  logic [IdxW-1:0]   winner_q, winner_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic              ack_q, ack_d;
  logic [IdxW-1:0]   ack_id_q, ack_id_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [15:0]       txn_cnt_q, txn_cnt_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [OD_W-1:0]   mem_rd_od_q, mem_rd_od_d;
  logic [DATA_W-1:0] mem_wd_data_q, mem_wd_data_d;

  logic [IdxW-1:0]   pick_idx;
  logic              pick_found;
  logic              load_issue;
  logic              lock_hold;

  common_mem_arbiter_rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

`ifdef MEM_ARB_LOCK_EN
  assign lock_hold = req_lock[winner_q] & req[winner_q];
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;
  assign lock_hold   = 1'b0;
`endif

  // Next-state and registered-output computation; mem_* are loaded one edge ahead of ISSUE.
  always_comb begin
    state_d       = state_q;
    winner_d      = winner_q;
    ptr_d         = ptr_q;
    gnt_d         = gnt_q;
    ack_d         = 1'b0;
    ack_id_d      = ack_id_q;
    rd_data_d     = rd_data_q;
    txn_cnt_d     = txn_cnt_q;
    mem_we_d      = 1'b0;
    mem_addr_d    = '0;
    mem_rd_od_d   = '0;
    mem_wd_data_d = '0;
    load_issue    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          winner_d   = pick_idx;
          load_issue = 1'b1;
          state_d    = StIssue;
        end
      end
      StIssue: begin
        if (!mem_we_q) begin
          rd_data_d = mem_rd_data;
        end
        ack_d     = 1'b1;
        ack_id_d  = winner_q;
        txn_cnt_d = txn_cnt_q + 16'd1;
        state_d   = StAck;
      end
      StAck: begin
        if (lock_hold) begin
          load_issue = 1'b1;
          state_d    = StIssue;
        end else begin
          gnt_d   = '0;
          ptr_d   = (winner_q == LastIdx) ? '0 : winner_q + IdxW'(1);
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (load_issue) begin
      gnt_d           = '0;
      gnt_d[winner_d] = 1'b1;
      mem_we_d        = req_we[winner_d];
      mem_addr_d      = req_addr[int'(winner_d)*ADDR_W +: ADDR_W];
      mem_rd_od_d     = req_rd_od[int'(winner_d)*OD_W +: OD_W];
      mem_wd_data_d   = req_wd_data[int'(winner_d)*DATA_W +: DATA_W];
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q       <= StIdle;
      winner_q      <= '0;
      ptr_q         <= '0;
      gnt_q         <= '0;
      ack_q         <= 1'b0;
      ack_id_q      <= '0;
      rd_data_q     <= '0;
      txn_cnt_q     <= '0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_rd_od_q   <= '0;
      mem_wd_data_q <= '0;
    end else begin
      state_q       <= state_d;
      winner_q      <= winner_d;
      ptr_q         <= ptr_d;
      gnt_q         <= gnt_d;
      ack_q         <= ack_d;
      ack_id_q      <= ack_id_d;
      rd_data_q     <= rd_data_d;
      txn_cnt_q     <= txn_cnt_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_rd_od_q   <= mem_rd_od_d;
      mem_wd_data_q <= mem_wd_data_d;
    end
  end

  assign gnt         = gnt_q;
  assign ack         = ack_q;
  assign ack_id      = ack_id_q;
  assign rd_data     = rd_data_q;
  assign txn_cnt     = txn_cnt_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_rd_od   = mem_rd_od_q;
  assign mem_wd_data = mem_wd_data_q;

endmodule

// File: tb/tb_common_mem_arbiter.sv
// Scoreboard bench for common_mem_arbiter: directed transactions push expected acks,
// a monitor pops and compares whenever ack is seen.
module tb_common_mem_arbiter;

  localparam int N  = 8;
  localparam int AW = 2;
  localparam int OW = 3;
  localparam int DW = 32;

  logic            clk_in = 1'b0;
  logic            rst;
  logic [N-1:0]    req, req_we, req_lock;
  logic [N*AW-1:0] req_addr;
  logic [N*OW-1:0] req_rd_od;
  logic [N*DW-1:0] req_wd_data;
  logic [N-1:0]    gnt;
  logic            ack;
  logic [2:0]      ack_id;
  logic [DW-1:0]   rd_data;
  logic [15:0]     txn_cnt;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [OW-1:0]   mem_rd_od;
  logic [DW-1:0]   mem_wd_data, mem_rd_data;

  common_mem_arbiter dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .req         (req),
    .req_we      (req_we),
    .req_lock    (req_lock),
    .req_addr    (req_addr),
    .req_rd_od   (req_rd_od),
    .req_wd_data (req_wd_data),
    .gnt         (gnt),
    .ack         (ack),
    .ack_id      (ack_id),
    .rd_data     (rd_data),
    .txn_cnt     (txn_cnt),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_rd_od   (mem_rd_od),
    .mem_wd_data (mem_wd_data),
    .mem_rd_data (mem_rd_data)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int          id;
    logic [31:0] data;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  exp_t        sb_head;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          we_cycles = 0;
  logic [15:0] exp_cnt = 16'd0;
  logic [31:0] last_rd = 32'd0;
  logic        mem_init;
  logic [31:0] mem [8][4];

  function automatic logic [31:0] pat(int o, int a);
    if (o == 3 && a == 2) return 32'hDEADBEEF;
    return 32'hA000_0000 | 32'(o << 8) | 32'(a);
  endfunction

  // Memory model: combinational read, write on the edge ending ISSUE.
  assign mem_rd_data = mem[mem_rd_od][mem_addr];
  always @(posedge clk_in) begin
    if (mem_init) begin
      for (int o = 0; o < 8; o++) for (int a = 0; a < 4; a++) mem[o][a] <= pat(o, a);
    end else if (mem_we) begin
      mem[mem_rd_od][mem_addr] <= mem_wd_data;
    end
  end

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare every ack against the head of the scoreboard.
  always @(posedge clk_in) begin
    #1;
    if (mem_we) we_cycles++;
    if (ack) begin
      chk("ack_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        sb_head = sb.pop_front();
        chk("ack_id", 32'(ack_id), 32'(sb_head.id));
        chk("rd_data", rd_data, sb_head.data);
        chk("txn_cnt", 32'(txn_cnt), 32'(sb_head.cnt));
      end
    end
  end

  task automatic expect_ack(input int id, input logic [31:0] data);
    exp_t e;
    exp_cnt = exp_cnt + 16'd1;
    e.id = id;
    e.data = data;
    e.cnt = exp_cnt;
    sb.push_back(e);
  endtask

  task automatic set_fields(input int id, input logic we, input logic [2:0] od,
                            input logic [1:0] a, input logic [31:0] d);
    req_we[id] = we;
    req_rd_od[id*OW +: OW] = od;
    req_addr[id*AW +: AW] = a;
    req_wd_data[id*DW +: DW] = d;
  endtask

  // Returns at the negedge inside the ACK cycle.
  task automatic wait_ack(output int t);
    int n = 0;
    t = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (!ack && n < 20);
    chk("ack_seen", 32'(ack), 32'd1);
    t = cyc;
  endtask

  // Returns 1 time unit after the edge that started ISSUE.
  task automatic wait_gnt(output int t);
    int n = 0;
    do begin
      @(posedge clk_in);
      #1;
      n++;
    end while (gnt == '0 && n < 20);
    chk("gnt_seen", 32'(gnt != '0), 32'd1);
    t = cyc;
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst = 1'b1;
    req = '0;
    req_lock = '0;
    @(negedge clk_in);
    rst = 1'b0;
    exp_cnt = 16'd0;
    last_rd = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0, t1, t2;
    rst = 1'b1;
    mem_init = 1'b1;
    req = '0;
    req_we = '0;
    req_lock = '0;
    req_addr = '0;
    req_rd_od = '0;
    req_wd_data = '0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst = 1'b0;
    mem_init = 1'b0;

    // Reset values
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_ack_id", 32'(ack_id), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_txn_cnt", 32'(txn_cnt), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_rd_od", 32'(mem_rd_od), 32'd0);
    chk("rst_mem_wd_data", mem_wd_data, 32'd0);

    // Requester 5 reads bank 3 addr 2
    set_fields(5, 1'b0, 3'd3, 2'd2, 32'd0);
    req = 8'h20;
    expect_ack(5, 32'hDEADBEEF);
    last_rd = 32'hDEADBEEF;
    wait_gnt(t0);
    chk("t1_gnt", 32'(gnt), 32'h20);
    chk("t1_mem_rd_od", 32'(mem_rd_od), 32'd3);
    chk("t1_mem_addr", 32'(mem_addr), 32'd2);
    chk("t1_mem_we", 32'(mem_we), 32'd0);
    wait_ack(t1);
    req = '0;
    chk("t1_latency", 32'(t1 - t0), 32'd1);
    chk("t1_gnt_in_ack", 32'(gnt), 32'h20);

    // Requester 0 writes then reads back bank 0 addr 1
    t0 = we_cycles;
    set_fields(0, 1'b1, 3'd0, 2'd1, 32'h12345678);
    req = 8'h01;
    expect_ack(0, last_rd);
    wait_ack(t1);
    req = '0;
    chk("t2_we_pulse", 32'(we_cycles - t0), 32'd1);
    chk("t2_mem_commit", mem[0][1], 32'h12345678);
    set_fields(0, 1'b0, 3'd0, 2'd1, 32'd0);
    req = 8'h01;
    expect_ack(0, 32'h12345678);
    last_rd = 32'h12345678;
    wait_ack(t1);
    req = '0;
    @(negedge clk_in);
    chk("t2_mem_we_idle", 32'(mem_we), 32'd0);
    chk("t2_gnt_idle", 32'(gnt), 32'd0);

    // Fairness from ptr 0 with all requesters held
    do_reset();
    for (int i = 0; i < N; i++) set_fields(i, 1'b0, 3'(i), 2'(i % 4), 32'd0);
    for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) expect_ack(i, pat(i, i % 4));
    last_rd = pat(7, 3);
    req = 8'hFF;
    t0 = 0;
    while (sb.size() != 0 && t0 < 100) begin
      @(negedge clk_in);
      t0++;
    end
    req = '0;
    chk("t3_drained", 32'(sb.size()), 32'd0);

    // Requester 2 drops req during ISSUE; write still completes
    set_fields(2, 1'b1, 3'd2, 2'd3, 32'hCAFEF00D);
    req = 8'h04;
    expect_ack(2, last_rd);
    wait_gnt(t0);
    chk("t4_gnt", 32'(gnt), 32'h04);
    req = '0;
    wait_ack(t1);
    chk("t4_mem_commit", mem[2][3], 32'hCAFEF00D);

    // Reset during ISSUE, then ptr restarts at 0
    set_fields(3, 1'b1, 3'd3, 2'd0, 32'h55AA55AA);
    req = 8'h08;
    wait_gnt(t0);
    chk("t5_gnt_issue", 32'(gnt), 32'h08);
    @(negedge clk_in);
    rst = 1'b1;
    req = '0;
    @(posedge clk_in);
    #1;
    chk("t5_gnt", 32'(gnt), 32'd0);
    chk("t5_mem_we", 32'(mem_we), 32'd0);
    chk("t5_txn_cnt", 32'(txn_cnt), 32'd0);
    chk("t5_ack", 32'(ack), 32'd0);
    @(negedge clk_in);
    rst = 1'b0;
    exp_cnt = 16'd0;
    set_fields(0, 1'b0, 3'd1, 2'd2, 32'd0);
    set_fields(7, 1'b0, 3'd7, 2'd1, 32'd0);
    expect_ack(0, pat(1, 2));
    expect_ack(7, pat(7, 1));
    req = 8'h81;
    wait_ack(t1);
    req[0] = 1'b0;
    wait_ack(t1);
    req = '0;

    // Move ptr to 4, then lock test with requesters 4 and 1
    set_fields(3, 1'b0, 3'd3, 2'd1, 32'd0);
    req = 8'h08;
    expect_ack(3, pat(3, 1));
    wait_ack(t1);
    req = '0;
    set_fields(4, 1'b0, 3'd4, 2'd0, 32'd0);
    set_fields(1, 1'b0, 3'd1, 2'd1, 32'd0);
    expect_ack(4, pat(4, 0));
`ifdef MEM_ARB_LOCK_EN
    expect_ack(4, pat(4, 0));
`endif
    expect_ack(1, pat(1, 1));
    req_lock = 8'h10;
    req = 8'h12;
    wait_ack(t1);
`ifdef MEM_ARB_LOCK_EN
    wait_ack(t2);
    chk("t6_lock_gap", 32'(t2 - t1), 32'd2);
    t1 = t2;
`endif
    req[4] = 1'b0;
    req_lock = '0;
    wait_ack(t2);
    req = '0;
    chk("t6_next_gap", 32'(t2 - t1), 32'd3);

    repeat (4) @(negedge clk_in);
    chk("end_sb_empty", 32'(sb.size()), 32'd0);
    chk("end_ack_low", 32'(ack), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/common_mem_arbiter.md
# common_mem_arbiter

Round-robin arbiter that shares one access port of the common memory block (we/addr/rd_od/wd_data/rd_data) between N requesters. It accepts independent read or write requests and grants one at a time. It drives the shared memory port for exactly one cycle per transaction and returns a registered read result with a one-cycle acknowledge pulse. It sits between the processing units and a single port slot of the common memory.

## Interface
- N_REQ, 8, number of requesters (2..8)
- ADDR_W, 2, word address width within a bank
- OD_W, 3, bank-select (rd_od) width
- DATA_W, 32, data width
- clk_in  input  1  clock, rising edge
- rst  input  1  reset; one clock; reset is synchronous and active-high
- req  input  N_REQ  per-requester request level
- req_we  input  N_REQ  per-requester write enable (1 = write, 0 = read)
- req_lock  input  N_REQ  keep grant for next transaction (only with MEM_ARB_LOCK_EN)
- req_addr  input  N_REQ*ADDR_W  flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_rd_od  input  N_REQ*OD_W  flattened bank selects
- req_wd_data  input  N_REQ*DATA_W  flattened write data
- gnt  output  N_REQ  one-hot grant, held through ISSUE and ACK
- ack  output  1  one-cycle completion pulse
- ack_id  output  3  index of completed requester, valid with ack
- rd_data  output  DATA_W  registered read result, valid with ack, held until next ack
- txn_cnt  output  16  completed-transaction counter, wraps at 0xFFFF -> 0
- mem_we  output  1  memory write enable
- mem_addr  output  ADDR_W  memory address
- mem_rd_od  output  OD_W  memory bank select
- mem_wd_data  output  DATA_W  memory write data
- mem_rd_data  input  DATA_W  combinational read data from memory

## Operation
- FSM: IDLE, ISSUE, ACK.
- IDLE: if any req bit is set, select a winner by round-robin from ptr, register its index, set gnt, and go to ISSUE. Otherwise stay in IDLE.
- ISSUE: drive mem_* from the winner's fields. mem_we = req_we[winner]. Capture mem_rd_data into rd_data (reads only; writes leave rd_data unchanged). Go to ACK.
- ACK: assert ack and ack_id. Increment txn_cnt. Set ptr = winner+1 mod N_REQ. Go to IDLE, or with lock see Configuration.
- Requesters hold req and all fields stable from request until ack. Dropping req after gnt does not cancel: the transaction completes.
- mem_we is 0 outside ISSUE. mem_addr, mem_rd_od and mem_wd_data are 0 outside ISSUE.
- Arbitration order: ptr, ptr+1, …, wrapping. Requesters with index ≥ N_REQ do not exist.
- No combinational path from req to mem_*. All outputs are registered or decoded from state only.

## Timing
- Reset values: state IDLE, ptr 0, gnt 0, ack 0, ack_id 0, rd_data 0, txn_cnt 0, mem_* 0.
- Request sampled at edge k. gnt and ISSUE start at k+1. The write commits, or read data is captured, at edge k+2. ack is high in cycle k+2.
- Throughput: one transaction per 3 cycles. With lock: one per 2 cycles.
- A new request is evaluated in the cycle after ack (IDLE). Re-request from the same requester in that cycle competes normally.
- rst asserted in any state: next edge returns everything to reset values. An in-flight write issued in the same cycle as rst is not guaranteed.

## Configuration
- MEM_ARB_LOCK_EN defined:
  - In ACK, if req_lock[winner] and req[winner] are both 1, go directly to ISSUE with the same winner. gnt is held and ptr is not advanced.
  - This allows atomic read-modify-write.
- MEM_ARB_LOCK_EN undefined: req_lock is ignored (port kept, unused). ACK always goes to IDLE.

## Structure
- Shared package: FSM state encoding (IDLE=0, ISSUE=1, ACK=2) and default widths (ADDR_W, OD_W, DATA_W).
- One sub-module: rr_pick. It is combinational, takes the req vector and ptr, and returns the winner index and a found flag. It is reused by other schedulers.

## Test plan
- Reset, then read: preload bank 3 addr 2 with 0xDEADBEEF. Requester 5 reads (rd_od=3, addr=2). Response: gnt=0x20 at k+1, ack with ack_id=5 and rd_data=0xDEADBEEF at k+2, txn_cnt=1.
- Write then read: requester 0 writes 0x12345678 to addr 1. Then requester 0 reads its own bank at addr 1. Response: mem_we high for exactly one cycle, and the read returns 0x12345678.
- Fairness: req=0xFF held for 16 transactions. Response: ack_id sequence is 0,1,…,7,0,…,7, and no requester is granted twice before all others.
- Drop req mid-transaction: requester 2 drops req in the ISSUE cycle. Response: ack is still asserted with ack_id=2, and the write is committed.
- Reset in ISSUE: assert rst during ISSUE. Response: next cycle state is IDLE, gnt=0, mem_we=0, txn_cnt=0, and ptr restarts at 0 (req=0x81 grants requester 0 first).
- Lock (MEM_ARB_LOCK_EN): requester 4 holds lock, and requester 1 also requests. Response: two back-to-back requester-4 transactions 2 cycles apart, then requester 1. Without the macro: requester 4 then requester 1.
